jesd204_tx_ctrl_64b: RTL and testbench
======================================

JESD204_TX_CTRL_64B -- requirements
Module: jesd204_tx_ctrl_64b

Interface
REQ-001 Parameter NUM_LANES, default 1, number of transmit lanes.
REQ-002 clk  input  1  single clock for all logic; one 64b/66b block per lane per beat.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 cfg_lanes_disable  input  NUM_LANES  per-lane disable; a disabled lane counts as PHY-ready.
REQ-005 cfg_mb_in_emb  input  8  multiblocks per extended multiblock minus one (E-1).
REQ-006 tx_en  input  1  link enable from the register map.
REQ-007 phy_ready  input  NUM_LANES  per-lane gearbox/PHY ready.
REQ-008 lemc_edge  input  1  one-cycle pulse marking the start of an extended multiblock.
REQ-009 tx_ready  output  1  data source may present valid payload this beat.
REQ-010 eomb  output  1  current beat is block 31 of a multiblock.
REQ-011 eoemb  output  1  current beat is the last block of an extended multiblock.
REQ-012 status_state  output  2  current state encoding.
REQ-013 event_phy_not_ready_error  output  1  one-cycle pulse on PHY loss while in DATA.
REQ-014 event_lemc_misalign  output  1  one-cycle pulse on lemc_edge arriving off the EMB boundary in DATA.

Function
REQ-015 all_phy_ready SHALL be the AND over lanes of (phy_ready | cfg_lanes_disable), using phy_ready registered once.
REQ-016 States SHALL be RESET=2'b00, WAIT_PHY=2'b01, EMB_ALIGN=2'b10, DATA=2'b11; status_state SHALL equal the state register.
REQ-017 tx_en low SHALL force next state RESET from any state, taking priority over all other transitions, with no error event.
REQ-018 RESET SHALL go to WAIT_PHY on the next cycle when tx_en is high.
REQ-019 WAIT_PHY SHALL run a 6-bit good counter while all_phy_ready is high, clearing it on any low cycle, and SHALL go to EMB_ALIGN on the cycle the counter equals 63 with all_phy_ready high.
REQ-020 The good counter SHALL be cleared in every state other than WAIT_PHY.
REQ-021 EMB_ALIGN SHALL go to WAIT_PHY if all_phy_ready is low; otherwise it SHALL go to DATA when lemc_edge is high.
REQ-022 DATA SHALL go to WAIT_PHY and pulse event_phy_not_ready_error if all_phy_ready is low.
REQ-023 The block counter (5 bits) and multiblock counter (8 bits) SHALL be loaded to 0 on any cycle where lemc_edge is high in EMB_ALIGN or DATA; the beat after the edge is block 0 of multiblock 0.
REQ-024 Otherwise in DATA, the block counter SHALL increment and wrap 31->0; the multiblock counter SHALL increment on block wrap and wrap to 0 after reaching cfg_mb_in_emb.
REQ-025 Outside DATA, both counters SHALL be held at 0.
REQ-026 eomb SHALL equal (state==DATA && block_cnt==31); eoemb SHALL equal (eomb && mb_cnt==cfg_mb_in_emb); both SHALL be combinational from registers.
REQ-027 tx_ready SHALL be high exactly when state==DATA.
REQ-028 In DATA, lemc_edge on a beat where eoemb is low SHALL pulse event_lemc_misalign and realign the counters per REQ-023; the state SHALL be unchanged.
REQ-029 In DATA without lemc_edge, counters SHALL free-run across EMB boundaries with no event.
REQ-030 PHY loss and lemc_edge in the same DATA cycle: PHY loss wins; only event_phy_not_ready_error pulses.
REQ-031 Both event outputs SHALL be registered, asserting the cycle after the triggering condition, for one cycle.

Reset
REQ-032 While resetn is low: state=RESET, counters=0, registered phy_ready=0, all outputs 0, status_state=2'b00.
REQ-033 Reset assertion mid-DATA SHALL drop tx_ready immediately without an error event.

Structure
REQ-034 State encodings SHALL be defined as localparams in this module; no shared package is required.
REQ-035 The block and multiblock counters SHALL be implemented in one sub-module, jesd204_tx_emb_counter.

Verification
REQ-036 Bring-up: tx_en=1 and all phy_ready=1 from reset; lemc_edge at cycle 100 -> DATA at cycle 101, tx_ready=1.
REQ-037 Counting with cfg_mb_in_emb=3: eomb every 32 beats; eoemb on beat 127 after the edge; a periodic lemc_edge at that beat -> no misalign event.
REQ-038 Misalign: lemc_edge at block 10 in DATA -> event_lemc_misalign for 1 cycle; block_cnt=0 on the next beat.
REQ-039 PHY loss: lane 0 phy_ready drops in DATA -> state WAIT_PHY, one error pulse; requires 64 good cycles before EMB_ALIGN.
REQ-040 Lane masking: NUM_LANES=4, lane 2 disabled with phy_ready[2]=0 -> normal bring-up.
REQ-041 Priority: tx_en low coincident with PHY loss in DATA -> RESET with no error pulse; resetn pulse mid-DATA -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/jesd204_tx_ctrl_64b_pkg.sv
// Shared widths and terminal counts for the JESD204 64b/66b TX link controller.
package jesd204_tx_ctrl_64b_pkg;
    localparam int BLK_W  = 5;
    localparam int MB_W   = 8;
    localparam int GOOD_W = 6;

    localparam logic [BLK_W-1:0]  BLK_LAST  = '1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = '1;
endpackage

// File: rtl/jesd204_tx_emb_counter.sv
// Block / multiblock position within the extended multiblock.
module jesd204_tx_emb_counter
    import jesd204_tx_ctrl_64b_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [MB_W-1:0]  mb_last_i,
    output logic [BLK_W-1:0] blk_cnt_o,
    output logic [MB_W-1:0]  mb_cnt_o
);
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [MB_W-1:0]  mb_q, mb_d;

    always_comb begin
        blk_d = '0;
        mb_d  = '0;
        // an edge realigns so the following beat is block 0 of multiblock 0
        if (!load_i && run_i) begin
            blk_d = blk_q + 1'b1;
            mb_d  = mb_q;
            if (blk_q == BLK_LAST)
                mb_d = (mb_q == mb_last_i) ? '0 : mb_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_q <= '0;
            mb_q  <= '0;
        end else begin
            blk_q <= blk_d;
            mb_q  <= mb_d;
        end
    end

    assign blk_cnt_o = blk_q;
    assign mb_cnt_o  = mb_q;
endmodule

// File: rtl/jesd204_tx_ctrl_64b.sv
// JESD204 64b/66b TX link controller: PHY qualification, EMB alignment, data framing.
module jesd204_tx_ctrl_64b
    import jesd204_tx_ctrl_64b_pkg::*;
#(
    parameter int NUM_LANES = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_LANES-1:0] cfg_lanes_disable,
    input  logic [7:0]           cfg_mb_in_emb,
    input  logic                 tx_en,
    input  logic [NUM_LANES-1:0] phy_ready,
    input  logic                 lemc_edge,
    output logic                 tx_ready,
    output logic                 eomb,
    output logic                 eoemb,
    output logic [1:0]           status_state,
    output logic                 event_phy_not_ready_error,
    output logic                 event_lemc_misalign
);
    typedef enum logic [1:0] {
        ST_RESET     = 2'b00,
        ST_WAIT_PHY  = 2'b01,
        ST_EMB_ALIGN = 2'b10,
        ST_DATA      = 2'b11
    } state_e;

    state_e                state_q, state_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic [NUM_LANES-1:0]  phy_q;
    logic                  err_q, err_d, mis_q, mis_d;
    logic                  all_phy_ready;
    logic [BLK_W-1:0]      blk_cnt;
    logic [MB_W-1:0]       mb_cnt;

    // disabled lanes never hold the link back
    assign all_phy_ready = &(phy_q | cfg_lanes_disable);

    jesd204_tx_emb_counter u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (lemc_edge && (state_q == ST_EMB_ALIGN || state_q == ST_DATA)),
        .run_i     (state_q == ST_DATA),
        .mb_last_i (cfg_mb_in_emb),
        .blk_cnt_o (blk_cnt),
        .mb_cnt_o  (mb_cnt)
    );

    assign eomb  = (state_q == ST_DATA) && (blk_cnt == BLK_LAST);
    assign eoemb = eomb && (mb_cnt == cfg_mb_in_emb);

    always_comb begin
        state_d = state_q;
        good_d  = '0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        if (!tx_en) begin
            state_d = ST_RESET;
        end else begin
            case (state_q)
                ST_RESET:    state_d = ST_WAIT_PHY;
                ST_WAIT_PHY: if (all_phy_ready) begin
                    good_d = good_q + 1'b1;
                    if (good_q == GOOD_LAST) state_d = ST_EMB_ALIGN;
                end
                ST_EMB_ALIGN: begin
                    if (!all_phy_ready)  state_d = ST_WAIT_PHY;
                    else if (lemc_edge)  state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (!all_phy_ready) begin
                        state_d = ST_WAIT_PHY;
                        err_d   = 1'b1;
                    end else if (lemc_edge && !eoemb) begin
                        mis_d   = 1'b1;
                    end
                end
                default:     state_d = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RESET;
            good_q  <= '0;
            phy_q   <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            phy_q   <= phy_ready;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign tx_ready                  = (state_q == ST_DATA);
    assign status_state              = state_q;
    assign event_phy_not_ready_error = err_q;
    assign event_lemc_misalign       = mis_q;
endmodule

// File: tb/tb_jesd204_tx_ctrl_64b.sv
// Randomized scoreboard bench for the JESD204 TX link controller.
module tb_jesd204_tx_ctrl_64b;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [NL-1:0] cfg_lanes_disable = '0;
    logic [7:0]    cfg_mb_in_emb = 8'd3;
    logic          tx_en = 1'b1;
    logic [NL-1:0] phy_ready = '1;
    logic          lemc_edge = 1'b0;
    logic          tx_ready, eomb, eoemb, ev_err, ev_mis;
    logic [1:0]    status_state;

    jesd204_tx_ctrl_64b #(.NUM_LANES(NL)) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .cfg_lanes_disable         (cfg_lanes_disable),
        .cfg_mb_in_emb             (cfg_mb_in_emb),
        .tx_en                     (tx_en),
        .phy_ready                 (phy_ready),
        .lemc_edge                 (lemc_edge),
        .tx_ready                  (tx_ready),
        .eomb                      (eomb),
        .eoemb                     (eoemb),
        .status_state              (status_state),
        .event_phy_not_ready_error (ev_err),
        .event_lemc_misalign       (ev_mis)
    );

    always #5 clk = ~clk;

    // {tx_ready, eomb, eoemb, state[1:0], phy_err, misalign}
    logic [6:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: link phase, run of good PHY cycles, beats since last alignment.
    int            m_mode = 0;
    int            m_good = 0;
    int            m_pos  = 0;
    logic [NL-1:0] m_phyq = '0;
    bit            m_err  = 0;
    bit            m_mis  = 0;

    function automatic int emb_len();
        return 32 * (int'(cfg_mb_in_emb) + 1);
    endfunction

    function automatic bit m_eoemb();
        return (m_mode == 3) && ((m_pos % emb_len()) == emb_len() - 1);
    endfunction

    function automatic logic [6:0] m_outputs();
        logic [1:0] st;
        bit         data;
        st   = 2'(m_mode);
        data = (m_mode == 3);
        return {data, data && (m_pos % 32 == 31), m_eoemb(), st, m_err, m_mis};
    endfunction

    task automatic model_step();
        bit allr, eo;
        int nmode;
        if (!resetn) begin
            m_mode = 0; m_good = 0; m_pos = 0; m_phyq = '0; m_err = 0; m_mis = 0;
            return;
        end
        allr  = &(m_phyq | cfg_lanes_disable);
        eo    = m_eoemb();
        m_err = (m_mode == 3) && tx_en && !allr;
        m_mis = (m_mode == 3) && tx_en && allr && lemc_edge && !eo;
        nmode = m_mode;
        if (!tx_en)                         nmode = 0;
        else if (m_mode == 0)               nmode = 1;
        else if (m_mode == 1)               nmode = (allr && m_good == 63) ? 2 : 1;
        else if (!allr)                     nmode = 1;
        else if (m_mode == 2 && lemc_edge)  nmode = 3;
        if ((m_mode == 2 || m_mode == 3) && lemc_edge) m_pos = 0;
        else if (m_mode == 3)                          m_pos = m_pos + 1;
        else                                           m_pos = 0;
        m_good = (m_mode == 1 && allr) ? (m_good + 1) % 64 : 0;
        m_mode = nmode;
        m_phyq = phy_ready;
    endtask

    task automatic cyc(input logic rn, input logic te, input logic [NL-1:0] phy,
                       input logic [NL-1:0] dis, input logic lemc);
        @(negedge clk);
        resetn = rn; tx_en = te; phy_ready = phy; cfg_lanes_disable = dis; lemc_edge = lemc;
        model_step();
        exp_q.push_back(m_outputs());
        if (!rn) begin
            #1;
            checks++;
            if ({tx_ready, eomb, eoemb, status_state, ev_err, ev_mis} !== 7'd0) begin
                failures++;
                $display("FAIL async_reset t=%0t got=%b want=0000000", $time,
                         {tx_ready, eomb, eoemb, status_state, ev_err, ev_mis});
            end
        end
    endtask

    // Pulse lemc_edge on the first EMB_ALIGN beat; bounded so a stuck link cannot hang.
    task automatic bring_up(input logic [NL-1:0] phy, input logic [NL-1:0] dis);
        int n = 0;
        while (m_mode != 3 && n < 400) begin
            cyc(1, 1, phy, dis, m_mode == 2);
            n++;
        end
        checks++;
        if (m_mode != 3) begin
            failures++;
            $display("FAIL bring_up_bound got_mode=%0d want=3", m_mode);
        end
    endtask

    task automatic run_aligned(input int n, input logic [NL-1:0] phy, input logic [NL-1:0] dis);
        for (int i = 0; i < n; i++) cyc(1, 1, phy, dis, m_eoemb());
    endtask

    initial begin : monitor
        logic [6:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {tx_ready, eomb, eoemb, status_state, ev_err, ev_mis};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL sb_outputs t=%0t got=%b want=%b (tx_ready,eomb,eoemb,state,err,mis)",
                             $time, a, e);
                end
            end
        end
    end

    initial begin : stim
        int n;
        logic rn, te, lm;
        logic [NL-1:0] ph;
        repeat (4) cyc(0, 1, '1, '0, 0);

        // bring-up with a single edge at cycle 100, then periodic aligned edges
        for (int c = 0; c < 100; c++) cyc(1, 1, '1, '0, 0);
        cyc(1, 1, '1, '0, 1);
        run_aligned(400, '1, '0);

        // misaligned edge at block 10
        n = 0;
        while (!(m_mode == 3 && m_pos % 32 == 10) && n < 100) begin cyc(1, 1, '1, '0, 0); n++; end
        cyc(1, 1, '1, '0, 1);
        run_aligned(160, '1, '0);

        // lane 0 PHY loss in DATA, requalify
        cyc(1, 1, 4'b1110, '0, 0);
        bring_up('1, '0);
        run_aligned(80, '1, '0);

        // lane 2 masked and not ready, shorter EMB
        cfg_mb_in_emb = 8'd0;
        cyc(0, 1, 4'b1011, 4'b0100, 0);
        bring_up(4'b1011, 4'b0100);
        run_aligned(120, 4'b1011, 4'b0100);

        // tx_en drop together with PHY loss, then reset pulse mid-DATA
        cyc(1, 0, 4'b1010, 4'b0100, 0);
        bring_up(4'b1011, 4'b0100);
        run_aligned(40, 4'b1011, 4'b0100);
        cyc(0, 1, 4'b1011, 4'b0100, 0);
        bring_up(4'b1011, 4'b0100);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rn = ($urandom % 900) != 0;
            te = ($urandom % 500) != 0;
            ph = '1;
            for (int l = 0; l < NL; l++) if ($urandom % 200 == 0) ph[l] = 1'b0;
            if (m_mode == 2)    lm = ($urandom % 4) == 0;
            else if (m_eoemb()) lm = ($urandom % 2) == 0;
            else                lm = ($urandom % 70) == 0;
            if (!rn) cfg_mb_in_emb = 8'($urandom_range(0, 3));
            cyc(rn, te, ph, 4'b0100, lm);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
